// File: rtl/qoi_pkg.sv
// qoi_pkg: definitions shared by the QOI encoder and decoder.
//   - chunk tags: full-byte RGB/RGBA tags and the 2-bit short-chunk tags
//   - decoder state encoding
//   - pixel byte-lane layout {A,B,G,R} (R in bits [7:0])
//   - qoi_hash(): index-table slot of a pixel, (R*3 + G*5 + B*7 + A*11) mod 64
// No ports; import with qoi_pkg::*.
package qoi_pkg;

  localparam logic [7:0] QOI_OP_RGB  = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA = 8'hFF;

  typedef enum logic [1:0] {
    TAG_INDEX = 2'd0,
    TAG_DIFF  = 2'd1,
    TAG_LUMA  = 2'd2,
    TAG_RUN   = 2'd3
  } qoi_tag_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_OPERAND,
    ST_EMIT,
    ST_RUN,
    ST_TAIL,
    ST_DONE
  } qoi_state_e;

  // Byte lanes of a pixel word: [31:24]=A, [23:16]=B, [15:8]=G, [7:0]=R.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } qoi_px_t;

  // Only the low 6 bits of each product survive mod 64, so the whole sum
  // is carried at 6 bits.
  function automatic logic [5:0] qoi_hash(input qoi_px_t p);
    return 6'(p.r) * 6'd3 + 6'(p.g) * 6'd5 + 6'(p.b) * 6'd7 + 6'(p.a) * 6'd11;
  endfunction

endpackage

// File: rtl/qoi_index_table.sv
// qoi_index_table: 64-entry x 32-bit table of recently seen pixels.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears every entry)
//   clear          single-cycle clear of every entry (new image)
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port; a same-cycle write is not visible
module qoi_index_table (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [64];

  // NOTE: every entry must read as zero after reset and after start, so this
  // table is built from resettable flops rather than a RAM macro.
  // NOTE: sequential state is written with <= so all flops update together
  // from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qoi_decode.sv
// qoi_decode: parses a QOI chunk byte stream and rebuilds RGBA pixels.
// Optional feature: define QOI_DEC_END_MARKER_EN to consume and check the
// 8-byte end marker (00 x7, 01) after the last pixel; otherwise DONE follows
// the last pixel directly.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, size         start pulse (honoured in IDLE/DONE) and pixel count
//   in_data/valid/ready encoded byte input handshake
//   px_o/valid/ready    pixel output handshake, px_o = {A,B,G,R}
//   px_last             marks the final pixel of the image
//   busy, done, err     status; err is sticky until the next start
//   count_o             pixels emitted so far
module qoi_decode
  import qoi_pkg::*;
#(
  parameter logic [31:0] INIT_PX = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] size,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] px_o,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [29:0] count_o
);

`ifdef QOI_DEC_END_MARKER_EN
  localparam qoi_state_e END_ST = ST_TAIL;
`else
  localparam qoi_state_e END_ST = ST_DONE;
`endif

  qoi_state_e  state_q, state_d;
  logic [29:0] size_q, count_q;
  qoi_px_t     prev_q, px_q, emit_px;
  logic        px_valid_q, px_last_q, err_q;
  logic [7:0]  op_q;                 // opcode held while its operands arrive
  logic [7:0]  acc_r, acc_g, acc_b;  // operand bytes collected so far
  logic [2:0]  idx_q;                // operand / end-marker byte position
  logic [5:0]  run_q, run_after;     // run pixels still owed
  logic        emit, is_last, slot_free, accept, start_ok;
  logic [7:0]  luma_dg;
  logic [31:0] rd_px;

  // A new pixel may be produced whenever the output register is empty or
  // is being drained this very cycle.
  assign slot_free = !px_valid_q || px_ready;
`ifdef QOI_DEC_END_MARKER_EN
  assign in_ready  = slot_free && (state_q inside {ST_OPCODE, ST_OPERAND, ST_TAIL});
`else
  assign in_ready  = slot_free && (state_q inside {ST_OPCODE, ST_OPERAND});
`endif
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign is_last   = (count_q == size_q - 30'd1);
  assign luma_dg   = {2'b00, op_q[5:0]} - 8'd32;

  qoi_index_table u_index (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .we    (emit),
    .waddr (qoi_hash(emit_px)),
    .wdata (emit_px),
    .raddr (in_data[5:0]),
    .rdata (rd_px)
  );

  // Pixels are produced on the edge that accepts their last byte, so a
  // pixel is valid the cycle after that byte.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_px   = prev_q;
    run_after = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (size == '0) ? END_ST : ST_OPCODE;
      end
      ST_OPCODE: begin
        if (accept) begin
          if (in_data == QOI_OP_RGB || in_data == QOI_OP_RGBA) begin
            state_d = ST_OPERAND;
          end else begin
            case (qoi_tag_e'(in_data[7:6]))
              TAG_INDEX: begin
                emit    = 1'b1;
                emit_px = rd_px;
              end
              TAG_DIFF: begin
                emit      = 1'b1;
                emit_px.r = prev_q.r + {6'd0, in_data[5:4]} - 8'd2;
                emit_px.g = prev_q.g + {6'd0, in_data[3:2]} - 8'd2;
                emit_px.b = prev_q.b + {6'd0, in_data[1:0]} - 8'd2;
              end
              TAG_LUMA: state_d = ST_OPERAND;
              default: begin  // run: first repeat goes out now
                emit      = 1'b1;
                run_after = in_data[5:0];
              end
            endcase
          end
        end
      end
      ST_OPERAND: begin
        if (accept) begin
          if (op_q == QOI_OP_RGB) begin
            if (idx_q == 3'd2) begin
              emit    = 1'b1;
              emit_px = {prev_q.a, in_data, acc_g, acc_r};
            end
          end else if (op_q == QOI_OP_RGBA) begin
            if (idx_q == 3'd3) begin
              emit    = 1'b1;
              emit_px = {in_data, acc_b, acc_g, acc_r};
            end
          end else begin  // LUMA second byte
            emit      = 1'b1;
            emit_px.r = prev_q.r + luma_dg + {4'd0, in_data[7:4]} - 8'd8;
            emit_px.g = prev_q.g + luma_dg;
            emit_px.b = prev_q.b + luma_dg + {4'd0, in_data[3:0]} - 8'd8;
          end
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          emit      = 1'b1;
          run_after = run_q - 6'd1;
        end
      end
      ST_EMIT: begin  // final pixel waiting for its handshake
        if (px_ready) state_d = END_ST;
      end
`ifdef QOI_DEC_END_MARKER_EN
      ST_TAIL: begin
        if (accept && idx_q == 3'd7) state_d = ST_DONE;
      end
`endif
      default: ;
    endcase
    if (emit) begin
      if (is_last)                state_d = ST_EMIT;
      else if (run_after != '0)   state_d = ST_RUN;
      else                        state_d = ST_OPCODE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      count_q    <= '0;
      prev_q     <= INIT_PX;
      px_q       <= '0;
      px_valid_q <= 1'b0;
      px_last_q  <= 1'b0;
      err_q      <= 1'b0;
      op_q       <= '0;
      acc_r      <= '0;
      acc_g      <= '0;
      acc_b      <= '0;
      idx_q      <= '0;
      run_q      <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        size_q  <= size;
        count_q <= '0;
        prev_q  <= INIT_PX;
        err_q   <= 1'b0;
        idx_q   <= '0;
        run_q   <= '0;
      end else begin
        if (px_valid_q && px_ready) begin
          px_valid_q <= 1'b0;
          px_last_q  <= 1'b0;
        end
        if (accept) begin
          case (state_q)
            ST_OPCODE: begin
              op_q  <= in_data;
              idx_q <= '0;
            end
            ST_OPERAND: begin
              idx_q <= idx_q + 3'd1;
              case (idx_q)
                3'd0:    acc_r <= in_data;
                3'd1:    acc_g <= in_data;
                default: acc_b <= in_data;
              endcase
            end
`ifdef QOI_DEC_END_MARKER_EN
            ST_TAIL: begin
              idx_q <= idx_q + 3'd1;
              if (in_data != ((idx_q == 3'd7) ? 8'h01 : 8'h00)) err_q <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
        if (emit) begin
          px_q       <= emit_px;
          px_valid_q <= 1'b1;
          px_last_q  <= is_last;
          prev_q     <= emit_px;
          count_q    <= count_q + 30'd1;
          run_q      <= run_after;
          idx_q      <= '0;  // end-marker position starts fresh
          // Run repeats beyond the image size are dropped.
          if (is_last && run_after != '0) err_q <= 1'b1;
        end
      end
    end
  end

  assign px_o     = px_q;
  assign px_valid = px_valid_q;
  assign px_last  = px_last_q;
  assign err      = err_q;
  assign count_o  = count_q;
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_qoi_decode.sv
// tb_qoi_decode: self-checking bench for qoi_decode. Directed images from the
// format rules plus random images, each compared against a chunk-level
// reference decoder. Honours QOI_DEC_END_MARKER_EN for the end marker.
module tb_qoi_decode;

  localparam logic [31:0] INIT_PX = 32'h0000_0000;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] pq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] size;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] px_o;
  logic        px_valid;
  logic        px_ready;
  logic        px_last;
  logic        busy;
  logic        done;
  logic        err;
  logic [29:0] count_o;

  int  total = 0;
  int  bad   = 0;
  bq_t stim;
  pq_t got_q;

  always #5 clk = ~clk;

  qoi_decode #(.INIT_PX(INIT_PX)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .size     (size),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .px_o     (px_o),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_last  (px_last),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .count_o  (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int px_hash(input logic [31:0] p);
    return (int'(p[7:0]) * 3 + int'(p[15:8]) * 5 + int'(p[23:16]) * 7 + int'(p[31:24]) * 11) % 64;
  endfunction

  // Reference decoder working chunk by chunk on the whole byte stream.
  function automatic void ref_decode(input bq_t s, input int sz, output pq_t pix, output bit e);
    logic [31:0] tbl [64];
    logic [7:0]  r, g, b, a, op, op2;
    int          i, n, dg;
    pix = {};
    e   = 1'b0;
    i   = 0;
    {a, b, g, r} = INIT_PX;
    for (int k = 0; k < 64; k++) tbl[k] = '0;
    while (pix.size() < sz && i < s.size()) begin
      op = s[i];
      i++;
      n = 1;
      if (op == 8'hFE) begin
        r = s[i]; g = s[i+1]; b = s[i+2];
        i += 3;
      end else if (op == 8'hFF) begin
        r = s[i]; g = s[i+1]; b = s[i+2]; a = s[i+3];
        i += 4;
      end else if (op[7:6] == 2'd0) begin
        {a, b, g, r} = tbl[op[5:0]];
      end else if (op[7:6] == 2'd1) begin
        r = 8'(int'(r) + int'(op[5:4]) - 2);
        g = 8'(int'(g) + int'(op[3:2]) - 2);
        b = 8'(int'(b) + int'(op[1:0]) - 2);
      end else if (op[7:6] == 2'd2) begin
        op2 = s[i];
        i++;
        dg = int'(op[5:0]) - 32;
        r = 8'(int'(r) + dg + int'(op2[7:4]) - 8);
        g = 8'(int'(g) + dg);
        b = 8'(int'(b) + dg + int'(op2[3:0]) - 8);
      end else begin
        n = int'(op[5:0]) + 1;
      end
      repeat (n) begin
        if (pix.size() < sz) begin
          pix.push_back({a, b, g, r});
          tbl[px_hash({a, b, g, r})] = {a, b, g, r};
        end else begin
          e = 1'b1;
        end
      end
    end
`ifdef QOI_DEC_END_MARKER_EN
    for (int k = 0; k < 8; k++)
      if (i + k >= s.size() || s[i+k] != ((k == 7) ? 8'h01 : 8'h00)) e = 1'b1;
`endif
  endfunction

  task automatic gen_stream(input int sz, output bq_t s);
    int pix, rem, len;
    s   = {};
    pix = 0;
    while (pix < sz) begin
      case ($urandom_range(0, 5))
        0: begin s.push_back(8'hFE); repeat (3) s.push_back(8'($urandom)); pix++; end
        1: begin s.push_back(8'hFF); repeat (4) s.push_back(8'($urandom)); pix++; end
        2: begin s.push_back({2'b00, 6'($urandom)}); pix++; end
        3: begin s.push_back({2'b01, 6'($urandom)}); pix++; end
        4: begin s.push_back({2'b10, 6'($urandom)}); s.push_back(8'($urandom)); pix++; end
        default: begin
          rem = sz - pix;
          len = $urandom_range(1, (rem > 62) ? 62 : rem);
          s.push_back({2'b11, 6'(len - 1)});
          pix += len;
        end
      endcase
    end
  endtask

  // mode 0: px_ready always 1; 1: random px_ready; 2: 5-cycle stall after 2 pixels.
  task automatic run_image(input string tag, input int sz, input bq_t s_in,
                           input int mode, input bit bad_mk);
    bq_t         s;
    pq_t         exp_px;
    bit          exp_err, stalled, last_hold;
    int          cyc, stall, hold_bad, last_bad, extra;
    logic [31:0] last_px;
    s = s_in;
`ifdef QOI_DEC_END_MARKER_EN
    for (int k = 0; k < 8; k++) s.push_back((k == 7) ? (bad_mk ? 8'h02 : 8'h01) : 8'h00);
`else
    if (bad_mk) s.push_back(8'h02);  // no marker: stray byte must stay unread
`endif
    ref_decode(s, sz, exp_px, exp_err);
    got_q     = {};
    stalled   = 1'b0;
    last_hold = 1'b0;
    last_px   = '0;
    stall     = 0;
    hold_bad  = 0;
    last_bad  = 0;
    extra     = 0;
    cyc       = 0;
    @(negedge clk);
    start = 1'b1;
    size  = 30'(sz);
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 20000) begin
      if (mode == 2 && !stalled && got_q.size() == 2) begin
        stall   = 5;
        stalled = 1'b1;
      end
      px_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : (stall == 0);
      if (stall > 0) stall--;
      in_valid = (s.size() > 0) && (mode == 2 || $urandom_range(0, 4) != 0);
      in_data  = (s.size() > 0) ? s[0] : 8'h00;
      #1;
      if (last_hold && (px_o !== last_px || px_valid !== 1'b1)) hold_bad++;
      if (px_valid && !px_ready && in_ready) hold_bad++;
      if (px_valid && px_ready) begin
        got_q.push_back(px_o);
        if (px_last !== (got_q.size() == sz)) last_bad++;
      end
      last_hold = px_valid && !px_ready;
      last_px   = px_o;
      if (in_valid && in_ready) void'(s.pop_front());
      @(negedge clk);
      cyc++;
    end
    // Bytes offered while DONE must never be taken.
    px_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      #1;
      if (in_ready) extra++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, " finished_in_budget"}, 32'(cyc < 20000), 32'd1);
    check({tag, " pixel_count"}, 32'(got_q.size()), 32'(exp_px.size()));
    for (int k = 0; k < exp_px.size(); k++)
      check($sformatf("%s px[%0d]", tag, k), (k < got_q.size()) ? got_q[k] : 32'hxxxx_xxxx, exp_px[k]);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " count_o"}, 32'(count_o), 32'(sz));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " hold_violations"}, 32'(hold_bad), 32'd0);
    check({tag, " px_last_errors"}, 32'(last_bad), 32'd0);
    check({tag, " bytes_left"}, 32'(s.size()), bad_mk ? 32'(s_in.size() == 0 ? 0 : 0) + 32'(s.size() != 0 && !bad_mk) : 32'd0);
    check({tag, " taken_in_done"}, 32'(extra), 32'd0);
    if (mode == 2) check({tag, " stall_applied"}, 32'(stalled), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " px_valid"}, 32'(px_valid), 32'd0);
    check({tag, " px_o"},     px_o,          32'd0);
    check({tag, " px_last"},  32'(px_last),  32'd0);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " done"},     32'(done),     32'd0);
    check({tag, " err"},      32'(err),      32'd0);
    check({tag, " count_o"},  32'(count_o),  32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t rs;
    rst      = 1'b1;
    start    = 1'b0;
    size     = '0;
    in_data  = '0;
    in_valid = 1'b0;
    px_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single RGB pixel.
    stim = {8'hFE, 8'h10, 8'h20, 8'h30};
    run_image("rgb1", 1, stim, 0, 1'b0);
    check("rgb1 value", got_q[0], 32'h0030_2010);

    // RGB, DIFF, RUN x3, INDEX back to the first pixel.
    stim = {8'hFE, 8'h10, 8'h20, 8'h30, 8'h7F, 8'hC2, 8'h20};
    run_image("mix6", 6, stim, 1, 1'b0);
    check("mix6 diff", got_q[1], 32'h0031_2111);
    check("mix6 run",  got_q[4], 32'h0031_2111);
    check("mix6 index", got_q[5], 32'h0030_2010);

    // LUMA after RGB.
    stim = {8'hFE, 8'h10, 8'h20, 8'h30, 8'h9F, 8'hA5};
    run_image("luma", 2, stim, 0, 1'b0);
    check("luma value", got_q[1], 32'h002C_1F11);

    // DIFF wrapping below zero from the initial pixel.
    stim = {8'h4A};
    run_image("wrap", 1, stim, 0, 1'b0);
    check("wrap value", got_q[0], 32'h0000_00FE);

    // Run of 4 into a 2-pixel image: truncated, err raised.
    stim = {8'hC3};
    run_image("overrun", 2, stim, 0, 1'b0);

    // Backpressure in the middle of a run.
    stim = {8'hFE, 8'h10, 8'h20, 8'h30, 8'hC5};
    run_image("stall", 7, stim, 2, 1'b0);

    // Empty image.
    stim = {};
    run_image("empty", 0, stim, 0, 1'b0);

`ifdef QOI_DEC_END_MARKER_EN
    stim = {8'hFE, 8'h10, 8'h20, 8'h30};
    run_image("badmark", 1, stim, 0, 1'b1);
`endif

    for (int n = 0; n < 10; n++) begin
      int sz;
      sz = $urandom_range(1, 40);
      gen_stream(sz, rs);
      run_image($sformatf("rand%0d", n), sz, rs, 1, 1'b0);
    end

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    size  = 30'd10;
    @(negedge clk);
    start    = 1'b0;
    px_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFE; @(negedge clk);
    in_data  = 8'h10; @(negedge clk);
    in_data  = 8'h20; @(negedge clk);
    in_data  = 8'h30; @(negedge clk);
    in_data  = 8'hC5; @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("midrun busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    stim = {8'hFE, 8'h40, 8'h50, 8'h60};
    run_image("recover", 1, stim, 0, 1'b0);
    check("recover value", got_q[0], 32'h0060_5040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
